soc_system_pio_key_in: RTL and testbench

Avalon-MM slave input PIO. It is the read-side counterpart of the LED output PIO.
- Samples WIDTH asynchronous push-button/switch inputs, synchronizes and debounces them.
- Latches selected edges into a sticky edge-capture register.
- Raises a level interrupt to the HPS bridge when any unmasked captured bit is set.
- Sits on the lightweight HPS-to-FPGA bus beside the LED PIO.

---
 rtl/soc_system_pio_pkg.sv | 14 +
 rtl/soc_system_pio_debounce.sv | 60 ++++++
 rtl/soc_system_pio_key_in.sv | 94 +++++++++
 tb/tb_soc_system_pio_key_in.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS lightweight-bridge PIO blocks:
// register word addresses and edge-capture selection codes.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RESERVED = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input bit: two-flop synchronizer followed by a stability counter that
// only lets the debounced value follow after DEBOUNCE_CYCLES differing cycles.
module soc_system_pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic debounced
);

  logic meta;
  logic sync_q;

  // Two-stage synchronizer for the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= RESET_BIT;
      sync_q <= RESET_BIT;
    end else begin
      meta   <= raw;
      sync_q <= meta;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // Debounce disabled: a single register stage after the synchronizer.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          debounced <= RESET_BIT;
        end else begin
          debounced <= sync_q;
        end
      end
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] count;

      // Count consecutive differing cycles; the counter clears before it can wrap.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count     <= CW'(0);
          debounced <= RESET_BIT;
        end else if (sync_q == debounced) begin
          count     <= CW'(0);
        end else if (count == LAST) begin
          count     <= CW'(0);
          debounced <= sync_q;
        end else begin
          count     <= count + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/soc_system_pio_key_in.sv
// Avalon-MM input PIO for push-buttons: debounced data, sticky edge capture
// with write-1-to-clear, and a maskable level interrupt.
module soc_system_pio_key_in
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = EDGE_FALL,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] deb_prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] cap_clear;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, writedata};
  assign wr_en        = chipselect & ~write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_BIT      (RESET_VALUE[i])
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (in_port[i]),
      .debounced(debounced[i])
    );
  end

  // Edge selection and write-1-to-clear decode.
  always_comb begin
    edges     = {WIDTH{1'b0}};
    cap_clear = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      EDGE_RISE: edges = debounced & ~deb_prev;
      EDGE_FALL: edges = ~debounced & deb_prev;
      EDGE_ANY:  edges = debounced ^ deb_prev;
      default:   edges = {WIDTH{1'b0}};
    endcase
    if (wr_en && (address == ADDR_EDGE_CAP)) begin
      cap_clear = writedata[WIDTH-1:0];
    end else begin
      cap_clear = {WIDTH{1'b0}};
    end
  end

  // Control/status registers; a new edge overrides a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev     <= RESET_VALUE;
      irq_mask     <= {WIDTH{1'b0}};
      edge_capture <= {WIDTH{1'b0}};
      irq          <= 1'b0;
    end else begin
      deb_prev     <= debounced;
      edge_capture <= (edge_capture & ~cap_clear) | edges;
      irq          <= |(edge_capture & irq_mask);
      if (wr_en && (address == ADDR_IRQ_MASK)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end else begin
        irq_mask <= irq_mask;
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:     readdata = 32'(debounced);
      ADDR_RESERVED: readdata = 32'd0;
      ADDR_IRQ_MASK: readdata = 32'(irq_mask);
      ADDR_EDGE_CAP: readdata = 32'(edge_capture);
      default:       readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_pio_key_in.sv
// Self-checking bench for soc_system_pio_key_in: directed scenarios plus a
// randomized run compared against a window-based behavioural model.
module tb_soc_system_pio_key_in;

  localparam int         WIDTH = 4;
  localparam int         DC    = 4;
  localparam logic [3:0] RV    = 4'hF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  soc_system_pio_key_in #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DC),
    .EDGE_TYPE      (1),
    .RESET_VALUE    (RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  // Reference model: a bit's debounced value flips once the last DC values
  // seen after the 2-cycle synchronizer delay all differ from it.
  logic [3:0] m_deb, m_prev, m_cap, m_mask;
  logic       m_irq;
  logic [3:0] dly_q[$];
  logic [3:0] seen_q[$];

  task automatic model_reset();
    m_deb  = RV;
    m_prev = RV;
    m_cap  = 4'h0;
    m_mask = 4'h0;
    m_irq  = 1'b0;
    dly_q  = {RV, RV};
    seen_q.delete();
  endtask

  task automatic model_step();
    logic [3:0] seen, nd, clr;
    bit         wr, stable;
    seen = dly_q.pop_front();
    dly_q.push_back(in_port);
    seen_q.push_back(seen);
    if (seen_q.size() > DC) seen_q.delete(0);
    nd = m_deb;
    if (seen_q.size() == DC) begin
      for (int b = 0; b < WIDTH; b++) begin
        stable = 1'b1;
        foreach (seen_q[k]) if (seen_q[k][b] == m_deb[b]) stable = 1'b0;
        if (stable) nd[b] = ~m_deb[b];
      end
    end
    wr     = chipselect && !write_n;
    clr    = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
    m_irq  = |(m_cap & m_mask);
    m_cap  = (m_cap & ~clr) | (m_prev & ~m_deb);
    if (wr && address == 2'd2) m_mask = writedata[3:0];
    m_prev = m_deb;
    m_deb  = nd;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_deb};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, v); total_cnt++;
    if (v !== 32'h0000_000F) $display("FAIL reset_data: got %h want %h", v, 32'hF); else pass_cnt++;
    rd(2'd2, v); total_cnt++;
    if (v !== 32'h0) $display("FAIL reset_mask: got %h want 0", v); else pass_cnt++;
    rd(2'd3, v); total_cnt++;
    if (v !== 32'h0) $display("FAIL reset_cap: got %h want 0", v); else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
    repeat (10) @(negedge clk);
    rd(2'd3, v); total_cnt++;
    if (v !== 32'h0) $display("FAIL post_reset_cap: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    in_port = 4'hE;
    repeat (3) @(negedge clk);
    in_port = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rd(2'd0, v); total_cnt++;
      if (v !== 32'hF) $display("FAIL glitch_data cyc %0d: got %h want %h", k, v, 32'hF); else pass_cnt++;
    end
    rd(2'd3, v); total_cnt++;
    if (v !== 32'h0) $display("FAIL glitch_cap: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_press();
    logic [31:0] v, e;
    in_port = 4'hE;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rd(2'd0, v); e = (k >= 6) ? 32'hE : 32'hF; total_cnt++;
      if (v !== e) $display("FAIL press_data cyc %0d: got %h want %h", k, v, e); else pass_cnt++;
      rd(2'd3, v); e = (k >= 7) ? 32'h1 : 32'h0; total_cnt++;
      if (v !== e) $display("FAIL press_cap cyc %0d: got %h want %h", k, v, e); else pass_cnt++;
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL press_irq cyc %0d: got %b want 0", k, irq); else pass_cnt++;
    end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    wr(2'd2, 32'h1);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_latency: got %b want 0", irq); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_set: got %b want 1", irq); else pass_cnt++;
    rd(2'd2, v); total_cnt++;
    if (v !== 32'h1) $display("FAIL mask_read: got %h want 1", v); else pass_cnt++;
    wr(2'd3, 32'h1);
    rd(2'd3, v); total_cnt++;
    if (v !== 32'h0) $display("FAIL w1c_cap: got %h want 0", v); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else pass_cnt++;
    wr(2'd0, 32'h0);
    rd(2'd0, v); total_cnt++;
    if (v !== 32'hE) $display("FAIL data_ro: got %h want %h", v, 32'hE); else pass_cnt++;
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    in_port = 4'hC;
    repeat (6) @(negedge clk);
    wr(2'd3, 32'h2);
    rd(2'd3, v); total_cnt++;
    if (v !== 32'h2) $display("FAIL set_wins_cap: got %h want 2", v); else pass_cnt++;
    rd(2'd0, v); total_cnt++;
    if (v !== 32'hC) $display("FAIL set_wins_data: got %h want %h", v, 32'hC); else pass_cnt++;
    wr(2'd3, 32'h2);
    rd(2'd3, v); total_cnt++;
    if (v !== 32'h0) $display("FAIL set_wins_clear: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v, e;
    in_port = 4'h8;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd2, v); total_cnt++;
    if (v !== 32'h0) $display("FAIL rst_mid_mask: got %h want 0", v); else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL rst_mid_irq: got %b want 0", irq); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rd(2'd0, v); e = (k >= 6) ? 32'h8 : 32'hF; total_cnt++;
      if (v !== e) $display("FAIL rst_mid_data cyc %0d: got %h want %h", k, v, e); else pass_cnt++;
      rd(2'd3, v); e = (k >= 7) ? 32'h7 : 32'h0; total_cnt++;
      if (v !== e) $display("FAIL rst_mid_cap cyc %0d: got %h want %h", k, v, e); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] v, e;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      rd(2'($urandom_range(0, 3)), v);
      e = model_read(address); total_cnt++;
      if (v !== e) $display("FAIL rand_read it %0d addr %0d: got %h want %h", n, address, v, e); else pass_cnt++;
      total_cnt++;
      if (irq !== m_irq) $display("FAIL rand_irq it %0d: got %b want %b", n, irq, m_irq); else pass_cnt++;
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'($urandom_range(0, 3));
        writedata  = $urandom;
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_irq();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
